// File: rtl/axis_drop_ctrl.sv
// Per-port drop controller for AXI-Stream droppers: PASS/DROP hysteresis on fill level,
// host force, minimum hold time and saturating drop-event counters.
// Optional stall-timeout trigger is built only when DROP_CTRL_STALL_TMO_EN is defined.
module axis_drop_ctrl #(
    parameter int PORT_COUNT  = 4,
    parameter int LEVEL_WIDTH = 16,
    parameter int HOLD_WIDTH  = 8,
    parameter int TMO_WIDTH   = 16,
    parameter int EVT_WIDTH   = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [PORT_COUNT*LEVEL_WIDTH-1:0] fill_level,
    input  logic [LEVEL_WIDTH-1:0]            hi_thresh,
    input  logic [LEVEL_WIDTH-1:0]            lo_thresh,
    input  logic [HOLD_WIDTH-1:0]             min_hold,
    input  logic [TMO_WIDTH-1:0]              stall_tmo,
    input  logic [PORT_COUNT-1:0]             force_drop,
    input  logic [PORT_COUNT-1:0]             mon_tvalid,
    input  logic [PORT_COUNT-1:0]             mon_tready,
    output logic [PORT_COUNT-1:0]             drop,
    output logic [PORT_COUNT*EVT_WIDTH-1:0]   drop_evt_count,
    output logic [PORT_COUNT-1:0]             stall_flag
);

    typedef enum logic {
        PASS = 1'b0,
        DROP = 1'b1
    } state_t;

`ifndef DROP_CTRL_STALL_TMO_EN
    logic unused_stall_inputs;
    assign unused_stall_inputs = ^{stall_tmo, mon_tvalid, mon_tready};
`endif

    for (genvar i = 0; i < PORT_COUNT; i++) begin : g_port
        state_t                 state_q, state_d;
        logic [HOLD_WIDTH-1:0]  hold_q, hold_d;
        logic [EVT_WIDTH-1:0]   evt_q, evt_d;
        logic                   flag_q, flag_d;
        logic [LEVEL_WIDTH-1:0] level;
        logic                   level_hit;
        logic                   stall_hit;
        logic                   exit_ok;

        assign level     = fill_level[i*LEVEL_WIDTH +: LEVEL_WIDTH];
        assign level_hit = (level >= hi_thresh);
        assign exit_ok   = !force_drop[i] && (level <= lo_thresh) && (hold_q == '0);

`ifdef DROP_CTRL_STALL_TMO_EN
        logic [TMO_WIDTH-1:0] stall_q, stall_d;
        logic [TMO_WIDTH:0]   stall_inc;

        // Extra bit keeps counter+1 from wrapping when the counter is saturated.
        assign stall_inc = {1'b0, stall_q} + (TMO_WIDTH+1)'(1);
        assign stall_hit = (stall_tmo != '0) && (stall_inc >= {1'b0, stall_tmo});

        always_comb begin
            stall_d = '0;
            if (state_q == PASS && mon_tvalid[i] && !mon_tready[i]) begin
                stall_d = (&stall_q) ? stall_q : stall_inc[TMO_WIDTH-1:0];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) stall_q <= '0;
            else     stall_q <= stall_d;
        end
`else
        assign stall_hit = 1'b0;
`endif

        // NOTE: every signal driven here gets a default first so no latch is inferred.
        always_comb begin
            state_d = state_q;
            hold_d  = hold_q;
            evt_d   = evt_q;
            flag_d  = flag_q;
            case (state_q)
                PASS: begin
                    // Entry is checked first, so it wins when exit would also hold.
                    if (force_drop[i] || level_hit || stall_hit) begin
                        state_d = DROP;
                        hold_d  = min_hold;
                        evt_d   = (&evt_q) ? evt_q : evt_q + EVT_WIDTH'(1);
                        flag_d  = stall_hit && !force_drop[i] && !level_hit;
                    end
                end
                DROP: begin
                    if (exit_ok) begin
                        state_d = PASS;
                        flag_d  = 1'b0;
                    end else if (hold_q != '0) begin
                        hold_d = hold_q - HOLD_WIDTH'(1);
                    end
                end
            endcase
        end

        // NOTE: sequential state uses non-blocking assignments only.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= PASS;
                hold_q  <= '0;
                evt_q   <= '0;
                flag_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                hold_q  <= hold_d;
                evt_q   <= evt_d;
                flag_q  <= flag_d;
            end
        end

        assign drop[i]                                   = (state_q == DROP);
        assign stall_flag[i]                             = flag_q;
        assign drop_evt_count[i*EVT_WIDTH +: EVT_WIDTH]  = evt_q;
    end

endmodule

// File: doc/axis_drop_ctrl.md
AXIS_DROP_CTRL -- requirements
Module: axis_drop_ctrl

Interface
REQ-001 SHALL have parameter PORT_COUNT, default 4: number of independently controlled ports.
REQ-002 SHALL have parameter LEVEL_WIDTH, default 16: width of each fill level and of each threshold.
REQ-003 SHALL have parameter HOLD_WIDTH, default 8: width of the minimum-drop-duration counter.
REQ-004 SHALL have parameter TMO_WIDTH, default 16: width of the stall timeout and stall counters.
REQ-005 SHALL have parameter EVT_WIDTH, default 16: width of each drop-event counter.
REQ-006 SHALL have ports, one per line (name, direction, width, meaning):
- clk  input  1  single clock for the whole block.
- rst  input  1  reset, synchronous to clk, active-high.
- fill_level  input  PORT_COUNT*LEVEL_WIDTH  per-port downstream buffer occupancy.
- hi_thresh  input  LEVEL_WIDTH  drop-entry threshold, shared by all ports.
- lo_thresh  input  LEVEL_WIDTH  drop-exit threshold, shared by all ports.
- min_hold  input  HOLD_WIDTH  minimum number of cycles a port stays in DROP.
- stall_tmo  input  TMO_WIDTH  stall cycles that trigger a drop; 0 disables the trigger.
- force_drop  input  PORT_COUNT  host override; forces the port into DROP.
- mon_tvalid  input  PORT_COUNT  monitored tvalid on the dropper output.
- mon_tready  input  PORT_COUNT  monitored tready on the dropper output.
- drop  output  PORT_COUNT  drop request; connects to the dropper's drop input.
- drop_evt_count  output  PORT_COUNT*EVT_WIDTH  per-port count of PASS-to-DROP entries.
- stall_flag  output  PORT_COUNT  set when the port entered DROP because of stall timeout.

Function
REQ-007 SHALL keep one 2-state FSM per port, PASS and DROP; each port is fully independent.
REQ-008 SHALL move PASS->DROP when any of these holds: force_drop[i]; fill_level[i] >= hi_thresh; the stall trigger fires (REQ-012).
REQ-009 SHALL move DROP->PASS only when all of these hold: !force_drop[i]; fill_level[i] <= lo_thresh; hold counter == 0.
REQ-010 SHALL register drop[i] = (state == DROP), giving 1-cycle latency from the causing input to drop.
REQ-011 Hold counter: load min_hold on PASS->DROP; decrement each cycle in DROP while nonzero; min_hold=0 allows exit on the next cycle.
REQ-012 Stall counter:
- increments each cycle in PASS while mon_tvalid[i] & !mon_tready[i], saturating at all-ones;
- clears on mon_tvalid & mon_tready, on !mon_tvalid, and in DROP;
- trigger fires when stall_tmo != 0 and counter + 1 >= stall_tmo.
REQ-013 stall_flag[i] SHALL set on a stall-caused entry and clear on DROP->PASS; force or level causes take priority over the flag (flag set only if stall was the sole cause).
REQ-014 drop_evt_count[i] SHALL increment by 1 on each PASS->DROP transition and saturate at all-ones (no wrap).
REQ-015 If hi_thresh <= lo_thresh, the FSM SHALL still follow REQ-008/009 literally; the result is a possible toggle every min_hold+1 cycles; no error is flagged.
REQ-016 Entry and exit conditions both true in PASS: entry wins. Inputs change mid-hold: exit is re-evaluated every cycle once hold reaches 0.

Reset
REQ-017 On rst: all FSMs go to PASS; drop=0; stall_flag=0; drop_evt_count=0; all hold and stall counters = 0.
REQ-018 rst asserted mid-DROP SHALL return the port to PASS on the next edge regardless of other inputs.

Configuration
REQ-019 Macro DROP_CTRL_STALL_TMO_EN:
- defined: stall counters and the stall trigger are implemented.
- undefined: stall counters are not instantiated; stall_tmo, mon_tvalid and mon_tready are ignored; stall_flag is tied to 0.

Verification
REQ-020 Hysteresis: hi=100, lo=20, min_hold=0; port 0 level 50->100->60->20. Required: drop[0] rises 1 cycle after 100, stays high at 60, falls 1 cycle after 20; evt count=1.
REQ-021 Hold: min_hold=5; force_drop pulsed 1 cycle, level 0. Required: drop high for exactly 6 cycles.
REQ-022 Stall (macro defined): stall_tmo=10; tvalid=1, tready=0 on port 2. Required: drop[2] rises on cycle 11 with stall_flag[2]=1; a handshake at cycle 9 prevents the drop.
REQ-023 Saturation: EVT_WIDTH=2; 5 force pulses, each separated by an exit. Required: count reads 3 and stays 3.
REQ-024 Reset mid-DROP with force_drop held: rst for 1 cycle. Required: drop=0 and count=0 after reset, then drop=1 one cycle after rst deasserts.
REQ-025 Macro undefined: stall_tmo=1 with a permanent stall. Required: drop stays 0 and stall_flag stays 0.
